// File: rtl/reset_seq_pkg.sv
// Shared types and widths for the reset sequencer and its timer.
// Retry constants are only consumed when RESET_SEQ_RETRY_EN is defined.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        GAP_WAIT = 2'd0,
        RELEASE  = 2'd1,
        ACK_WAIT = 2'd2,
        RUN      = 2'd3
    } seq_state_t;

    localparam int CNT_W     = 16;
    localparam int IDX_W     = 3;
    localparam int MAX_RETRY = 2;

endpackage

// File: rtl/seq_timer.sv
// Loadable 16-bit down-counter with enable and zero flag; used for gap and ack timeout.
// Latency: load/decrement visible the cycle after the request. No backpressure.
// Reset value is a parameter so the first gap starts counting straight out of reset.
module seq_timer
    import reset_seq_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-stage resets in order, each after a settle gap and the previous stage's ack.
// Latency: stage 0 released GAP edges after rst drops; optional retries under RESET_SEQ_RETRY_EN.
// Backpressure: none; missing acks are bounded by TIMEOUT and flagged through fault.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int STAGES  = 4,
    parameter int GAP     = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stage_done,
    output logic [STAGES-1:0] stage_rst,
    output logic              all_ready,
    output logic              fault,
    output logic [IDX_W-1:0]  fault_stage
);

    localparam logic [CNT_W-1:0] GAP_V = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] TMO_V = CNT_W'(TIMEOUT);

    seq_state_t        state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [STAGES-1:0] idx_mask;
    logic              done_sel;
    logic              is_last;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_en;
    logic [CNT_W-1:0]  tmr_count;
    logic              tmr_zero;
    logic              tmr_expire;

    logic              do_release;
    logic              do_advance;
    logic              do_timeout;

`ifdef RESET_SEQ_RETRY_EN
    logic              do_retry;
    logic [1:0]        retry_cnt;
`endif

    seq_timer #(
        .RST_VAL (GAP_V)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // Count of 1 marks the final cycle of a window; zero is only a safety net.
    assign tmr_expire = tmr_zero || (tmr_count == CNT_W'(1));

    always_comb begin
        idx_mask = '0;
        for (int i = 0; i < STAGES; i++) begin
            idx_mask[i] = (idx == IDX_W'(i));
        end
    end

    assign done_sel = |(stage_done & idx_mask);
    assign is_last  = (idx == IDX_W'(STAGES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= GAP_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tmr_load   = 1'b0;
        tmr_val    = GAP_V;
        tmr_en     = 1'b0;
        do_release = 1'b0;
        do_advance = 1'b0;
        do_timeout = 1'b0;
`ifdef RESET_SEQ_RETRY_EN
        do_retry   = 1'b0;
`endif
        case (state)
            GAP_WAIT: begin
                // Reset drops on the last gap edge, so RELEASE is the first deasserted cycle.
                if (tmr_expire) begin
                    do_release = 1'b1;
                    state_nxt  = RELEASE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RELEASE: begin
                tmr_load  = 1'b1;
                tmr_val   = TMO_V;
                state_nxt = ACK_WAIT;
            end
            ACK_WAIT: begin
                if (done_sel) begin
                    do_advance = 1'b1;
                end else if (tmr_expire) begin
`ifdef RESET_SEQ_RETRY_EN
                    if (retry_cnt < 2'(MAX_RETRY)) begin
                        do_retry  = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = GAP_V;
                        state_nxt = GAP_WAIT;
                    end else begin
                        do_timeout = 1'b1;
                        do_advance = 1'b1;
                    end
`else
                    do_timeout = 1'b1;
                    do_advance = 1'b1;
`endif
                end else begin
                    tmr_en = 1'b1;
                end
                if (do_advance) begin
                    if (is_last) begin
                        state_nxt = RUN;
                    end else begin
                        tmr_load  = 1'b1;
                        tmr_val   = GAP_V;
                        state_nxt = GAP_WAIT;
                    end
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = GAP_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_rst   <= '1;
            idx         <= '0;
            all_ready   <= 1'b0;
            fault       <= 1'b0;
            fault_stage <= '0;
        end else begin
            if (do_release) begin
                stage_rst <= stage_rst & ~idx_mask;
            end
`ifdef RESET_SEQ_RETRY_EN
            if (do_retry) begin
                stage_rst <= stage_rst | idx_mask;
            end
`endif
            if (do_advance && !is_last) begin
                idx <= idx + IDX_W'(1);
            end
            if (do_advance && is_last) begin
                all_ready <= 1'b1;
            end
            // Only the first failing stage is recorded.
            if (do_timeout) begin
                fault <= 1'b1;
                if (!fault) begin
                    fault_stage <= idx;
                end
            end
        end
    end

`ifdef RESET_SEQ_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt <= '0;
        end else if (do_advance) begin
            retry_cnt <= '0;
        end else if (do_retry) begin
            retry_cnt <= retry_cnt + 2'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (STAGES=4, GAP=8, TIMEOUT=20) with an expectation queue.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] stage_done = 4'h0;
    logic [3:0] stage_rst;
    logic       all_ready;
    logic       fault;
    logic [2:0] fault_stage;

    reset_sequencer #(
        .STAGES  (4),
        .GAP     (8),
        .TIMEOUT (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stage_done  (stage_done),
        .stage_rst   (stage_rst),
        .all_ready   (all_ready),
        .fault       (fault),
        .fault_stage (fault_stage)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] srst;
        logic       rdy;
        logic       flt;
        logic [2:0] fs;
    } exp_t;

    typedef struct {
        int         cyc;
        logic       r;
        logic [3:0] done;
    } drv_t;

    exp_t exp_q[$];
    drv_t drv_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   test_id  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_at(input int c, input logic [3:0] s, input logic r,
                             input logic f, input logic [2:0] fs);
        exp_t e;
        e.cyc = c; e.srst = s; e.rdy = r; e.flt = f; e.fs = fs;
        exp_q.push_back(e);
    endtask

    task automatic drive_at(input int c, input logic r, input logic [3:0] d);
        drv_t v;
        v.cyc = c; v.r = r; v.done = d;
        drv_q.push_back(v);
    endtask

    task automatic apply_drv(input int c);
        drv_t v;
        while (drv_q.size() > 0 && drv_q[0].cyc == c) begin
            v = drv_q.pop_front();
            rst = v.r;
            stage_done = v.done;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        stage_done = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk($sformatf("t%0d reset stage_rst", test_id), stage_rst, 4'hF);
        chk($sformatf("t%0d reset all_ready", test_id), all_ready, 1'b0);
        chk($sformatf("t%0d reset fault", test_id), fault, 1'b0);
        chk($sformatf("t%0d reset fault_stage", test_id), fault_stage, 3'd0);
    endtask

    // Edge k is the k-th edge after rst was first sampled low; outputs checked at the following negedge.
    task automatic run_check(input int ncyc);
        exp_t e;
        apply_drv(0);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc == k) begin
                e = exp_q.pop_front();
                chk($sformatf("t%0d@%0d stage_rst", test_id, k), stage_rst, e.srst);
                chk($sformatf("t%0d@%0d all_ready", test_id, k), all_ready, e.rdy);
                chk($sformatf("t%0d@%0d fault", test_id, k), fault, e.flt);
                chk($sformatf("t%0d@%0d fault_stage", test_id, k), fault_stage, e.fs);
            end
            apply_drv(k + 1);
        end
        chk($sformatf("t%0d unconsumed expectations", test_id), exp_q.size(), 0);
        exp_q.delete();
        drv_q.delete();
    endtask

    initial begin
        // 1: immediate acks, nominal release cadence.
        test_id = 1;
        do_reset();
        drive_at(0, 1'b0, 4'hF);
        expect_at(6,  4'hF, 1'b0, 1'b0, 3'd0);
        expect_at(7,  4'hE, 1'b0, 1'b0, 3'd0);
        expect_at(16, 4'hE, 1'b0, 1'b0, 3'd0);
        expect_at(17, 4'hC, 1'b0, 1'b0, 3'd0);
        expect_at(26, 4'hC, 1'b0, 1'b0, 3'd0);
        expect_at(27, 4'h8, 1'b0, 1'b0, 3'd0);
        expect_at(37, 4'h0, 1'b0, 1'b0, 3'd0);
        expect_at(38, 4'h0, 1'b0, 1'b0, 3'd0);
        expect_at(39, 4'h0, 1'b1, 1'b0, 3'd0);
        expect_at(44, 4'h0, 1'b1, 1'b0, 3'd0);
        run_check(45);

        // 2: stage 2 never acks; exactly 20 ack cycles then fault and continue.
        test_id = 2;
        do_reset();
        drive_at(0, 1'b0, 4'hB);
        expect_at(27, 4'h8, 1'b0, 1'b0, 3'd0);
        expect_at(47, 4'h8, 1'b0, 1'b0, 3'd0);
        expect_at(48, 4'h8, 1'b0, 1'b1, 3'd2);
        expect_at(55, 4'h8, 1'b0, 1'b1, 3'd2);
        expect_at(56, 4'h0, 1'b0, 1'b1, 3'd2);
        expect_at(57, 4'h0, 1'b0, 1'b1, 3'd2);
        expect_at(58, 4'h0, 1'b1, 1'b1, 3'd2);
        run_check(60);

        // 3: stage 1 done high only up to RELEASE, low during ACK_WAIT.
        test_id = 3;
        do_reset();
        drive_at(0,  1'b0, 4'hF);
        drive_at(19, 1'b0, 4'hD);
        expect_at(18, 4'hC, 1'b0, 1'b0, 3'd0);
        expect_at(37, 4'hC, 1'b0, 1'b0, 3'd0);
        expect_at(38, 4'hC, 1'b0, 1'b1, 3'd1);
        expect_at(46, 4'h8, 1'b0, 1'b1, 3'd1);
        expect_at(56, 4'h0, 1'b0, 1'b1, 3'd1);
        expect_at(58, 4'h0, 1'b1, 1'b1, 3'd1);
        run_check(60);

        // 4: rst pulse during stage 2 ACK_WAIT with fault set, then clean restart.
        test_id = 4;
        do_reset();
        drive_at(0,  1'b0, 4'h9);
        drive_at(50, 1'b1, 4'h9);
        drive_at(51, 1'b0, 4'hF);
        expect_at(38, 4'hC, 1'b0, 1'b1, 3'd1);
        expect_at(49, 4'h8, 1'b0, 1'b1, 3'd1);
        expect_at(50, 4'hF, 1'b0, 1'b0, 3'd0);
        expect_at(57, 4'hF, 1'b0, 1'b0, 3'd0);
        expect_at(58, 4'hE, 1'b0, 1'b0, 3'd0);
        expect_at(88, 4'h0, 1'b0, 1'b0, 3'd0);
        expect_at(89, 4'h0, 1'b0, 1'b0, 3'd0);
        expect_at(90, 4'h0, 1'b1, 1'b0, 3'd0);
        run_check(92);

        // 5: stages 1 and 3 time out; first faulting index is kept.
        test_id = 5;
        do_reset();
        drive_at(0, 1'b0, 4'h5);
        expect_at(38, 4'hC, 1'b0, 1'b1, 3'd1);
        expect_at(48, 4'h8, 1'b0, 1'b1, 3'd1);
        expect_at(56, 4'h0, 1'b0, 1'b1, 3'd1);
        expect_at(76, 4'h0, 1'b0, 1'b1, 3'd1);
        expect_at(77, 4'h0, 1'b1, 1'b1, 3'd1);
        run_check(80);

        test_id = 6;
        do_reset();
`ifdef RESET_SEQ_RETRY_EN
        // 6: stage 0 retried twice (8-cycle reset pulses), acks during the 3rd attempt.
        drive_at(0,  1'b0, 4'hE);
        drive_at(70, 1'b0, 4'hF);
        expect_at(27,  4'hE, 1'b0, 1'b0, 3'd0);
        expect_at(28,  4'hF, 1'b0, 1'b0, 3'd0);
        expect_at(35,  4'hF, 1'b0, 1'b0, 3'd0);
        expect_at(36,  4'hE, 1'b0, 1'b0, 3'd0);
        expect_at(56,  4'hE, 1'b0, 1'b0, 3'd0);
        expect_at(57,  4'hF, 1'b0, 1'b0, 3'd0);
        expect_at(64,  4'hF, 1'b0, 1'b0, 3'd0);
        expect_at(65,  4'hE, 1'b0, 1'b0, 3'd0);
        expect_at(77,  4'hE, 1'b0, 1'b0, 3'd0);
        expect_at(78,  4'hC, 1'b0, 1'b0, 3'd0);
        expect_at(98,  4'h0, 1'b0, 1'b0, 3'd0);
        expect_at(100, 4'h0, 1'b1, 1'b0, 3'd0);
        run_check(102);
`else
        // 6: without retries stage 0 faults on its first timeout and the sequence moves on.
        drive_at(0, 1'b0, 4'hE);
        expect_at(27, 4'hE, 1'b0, 1'b0, 3'd0);
        expect_at(28, 4'hE, 1'b0, 1'b1, 3'd0);
        expect_at(35, 4'hE, 1'b0, 1'b1, 3'd0);
        expect_at(36, 4'hC, 1'b0, 1'b1, 3'd0);
        run_check(40);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
